// File: rtl/lkh_route_pkg.sv
// Shared definitions for the look-ahead route stage.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: packet framing FSM encoding, mesh port numbering, default
// destport width and flit field-offset helpers used for parameter defaults.
package lkh_route_pkg;

  // Packet framing state: between packets, or inside a multi-flit packet.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } pkt_state_e;

  // Mesh output port numbering. NORTH is towards decreasing y,
  // SOUTH towards increasing y.
  localparam int PORT_LOCAL = 0;
  localparam int PORT_EAST  = 1;
  localparam int PORT_NORTH = 2;
  localparam int PORT_WEST  = 3;
  localparam int PORT_SOUTH = 4;

  // Default router port count (4 mesh directions + local).
  localparam int DEF_P = 5;

  // destport field carries one entry per non-self port.
  function automatic int dstpw_of(input int p);
    return p - 1;
  endfunction

  // Destination-address field sits directly above the destport field.
  function automatic int da_lsb_of(input int dstp_lsb, input int dstpw);
    return dstp_lsb + dstpw;
  endfunction

  // Source-address field sits directly above the destination-address field.
  function automatic int sa_lsb_of(input int da_lsb, input int daw);
    return da_lsb + daw;
  endfunction

endpackage

// File: rtl/lkh_flit_skid_buf.sv
// Two-entry skid buffer (main + skid register) for W-bit flits.
// Latency: 1 cycle from in_vld&&in_rdy to out_vld when empty; 1 flit/cycle sustained.
// Backpressure: in_rdy = !skid full (registered); skid absorbs the flit in flight when out_rdy drops.
//
// Ports: in_dat/in_vld/in_rdy upstream, out_dat/out_vld/out_rdy downstream.
// out_dat is a register output and holds while out_vld && !out_rdy.
module lkh_flit_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic         push, pop;

  assign push = in_vld && !skid_vld_q;
  assign pop  = main_vld_q && out_rdy;

  // Skid can only be occupied while main is occupied, so an empty main
  // always takes the incoming flit directly.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q) begin
      if (push) begin
        main_d     = in_dat;
        main_vld_d = 1'b1;
      end
    end else if (pop) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (push) begin
        main_d = in_dat;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (push) begin
      skid_d     = in_dat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_rdy  = !skid_vld_q;
  assign out_dat = main_q;
  assign out_vld = main_vld_q;

endmodule

// File: rtl/look_ahead_routing.sv
// Look-ahead route computation: output port to use at the NEXT router.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports: current_r_addr / neighbors_r_addr (router addresses, quasi-static),
// dest_e_addr / src_e_addr (flit addresses), destport (port taken at this
// router), lkdestport (port to take at the router behind destport).
// Router and endpoint addresses are linear: addr = y*T1 + x.
module look_ahead_routing
  import lkh_route_pkg::*;
#(
  parameter int    NOC_ID     = 0,
  parameter int    P          = DEF_P,
  parameter int    T1         = 8,
  parameter int    T2         = 8,
  parameter int    T3         = 8,
  parameter int    T4         = 8,
  parameter int    RAw        = 3,
  parameter int    EAw        = 3,
  parameter int    DAw        = 3,
  parameter int    DSTPw      = dstpw_of(P),
  parameter string TOPOLOGY   = "MESH",
  parameter string ROUTE_NAME = "XY",
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    SW_LOC     = 0
) (
  input  logic [RAw-1:0]   current_r_addr,
  input  logic [P*RAw-1:0] neighbors_r_addr,
  input  logic [DAw-1:0]   dest_e_addr,
  input  logic [EAw-1:0]   src_e_addr,
  input  logic [DSTPw-1:0] destport,
  output logic [DSTPw-1:0] lkdestport
);

  // Only deterministic XY on a 2-D mesh is implemented; any other
  // configuration delivers locally so the flit is never misrouted.
  localparam bit CFG_OK = (TOPOLOGY == "MESH") && (ROUTE_NAME == "XY") &&
                          (ROUTE_TYPE == "DETERMINISTIC") && (T1 >= 1) &&
                          (T2 >= 1) && (T3 >= 1) && (T4 >= 1) &&
                          (NOC_ID >= 0) && (SW_LOC < P);

  // XY routing ignores the source address.
  logic unused_src;
  assign unused_src = ^src_e_addr;

  if (CFG_OK) begin : g_mesh_xy
    logic [RAw-1:0] next_addr;
    int nx, ny, tx, ty;

    always_comb begin
      // LOCAL (or an out-of-range port) means the flit ejects here, so the
      // "next" router is this one and XY will resolve to LOCAL.
      next_addr = current_r_addr;
      for (int i = 1; i < P; i++) begin
        if (int'(destport) == i) next_addr = neighbors_r_addr[i*RAw +: RAw];
      end
      nx = int'(next_addr) % T1;
      ny = int'(next_addr) / T1;
      tx = int'(dest_e_addr) % T1;
      ty = int'(dest_e_addr) / T1;

      // X first, then Y.
      if (tx > nx)      lkdestport = DSTPw'(PORT_EAST);
      else if (tx < nx) lkdestport = DSTPw'(PORT_WEST);
      else if (ty > ny) lkdestport = DSTPw'(PORT_SOUTH);
      else if (ty < ny) lkdestport = DSTPw'(PORT_NORTH);
      else              lkdestport = DSTPw'(PORT_LOCAL);
    end
  end else begin : g_unsupported
    logic unused_cfg;
    assign unused_cfg = ^{current_r_addr, neighbors_r_addr, dest_e_addr, destport};
    assign lkdestport = DSTPw'(PORT_LOCAL);
  end

endmodule

// File: rtl/lkh_route_stage.sv
// Registered look-ahead route stage: rewrites header destport with the next router's port.
// Latency: 1 cycle (flit registered in a two-entry skid buffer), 1 flit/cycle sustained.
// Backpressure: valid/ready; in_ready is registered, two flits absorbed after out_ready drops.
//
// Ports: clk, reset (sync, active-high); current_r_addr, neighbors_r_addr
// (quasi-static addresses); in_flit/in_valid/in_ready upstream;
// out_flit/out_valid/out_ready downstream; cur_lkdestport (look-ahead port of
// the last header forwarded); proto_err (sticky framing error).
// Optional framing check: define LKH_ROUTE_CHECK_EN; otherwise proto_err is 0.
module lkh_route_stage
  import lkh_route_pkg::*;
#(
  parameter int    NOC_ID     = 0,
  parameter int    P          = DEF_P,
  parameter int    T1         = 8,
  parameter int    T2         = 8,
  parameter int    T3         = 8,
  parameter int    T4         = 8,
  parameter int    RAw        = 3,
  parameter int    EAw        = 3,
  parameter int    DAw        = 3,
  parameter int    DSTPw      = dstpw_of(P),
  parameter string TOPOLOGY   = "MESH",
  parameter string ROUTE_NAME = "XY",
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    SW_LOC     = 0,
  parameter int    Fw         = 64,
  parameter int    HDR_BIT    = Fw - 1,
  parameter int    TAIL_BIT   = Fw - 2,
  parameter int    DSTP_LSB   = 0,
  parameter int    DA_LSB     = da_lsb_of(DSTP_LSB, DSTPw),
  parameter int    SA_LSB     = sa_lsb_of(DA_LSB, DAw)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RAw-1:0]   current_r_addr,
  input  logic [P*RAw-1:0] neighbors_r_addr,
  input  logic [Fw-1:0]    in_flit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Fw-1:0]    out_flit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSTPw-1:0] cur_lkdestport,
  output logic             proto_err
);

  logic             hdr_in, tail_in, in_xfer, out_xfer;
  logic [DSTPw-1:0] lkdestport;
  logic [Fw-1:0]    buf_in_flit;
  pkt_state_e       state_q, state_d;
  logic [DSTPw-1:0] cur_lkdestport_q, cur_lkdestport_d;

  assign hdr_in   = in_flit[HDR_BIT];
  assign tail_in  = in_flit[TAIL_BIT];
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  look_ahead_routing #(
    .NOC_ID    (NOC_ID),
    .P         (P),
    .T1        (T1),
    .T2        (T2),
    .T3        (T3),
    .T4        (T4),
    .RAw       (RAw),
    .EAw       (EAw),
    .DAw       (DAw),
    .DSTPw     (DSTPw),
    .TOPOLOGY  (TOPOLOGY),
    .ROUTE_NAME(ROUTE_NAME),
    .ROUTE_TYPE(ROUTE_TYPE),
    .SW_LOC    (SW_LOC)
  ) u_route (
    .current_r_addr  (current_r_addr),
    .neighbors_r_addr(neighbors_r_addr),
    .dest_e_addr     (in_flit[DA_LSB +: DAw]),
    .src_e_addr      (in_flit[SA_LSB +: EAw]),
    .destport        (in_flit[DSTP_LSB +: DSTPw]),
    .lkdestport      (lkdestport)
  );

  // Route is resolved on the input side so out_flit stays a pure register.
  always_comb begin
    buf_in_flit = in_flit;
    if (hdr_in) buf_in_flit[DSTP_LSB +: DSTPw] = lkdestport;
  end

  lkh_flit_skid_buf #(
    .W(Fw)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .in_dat (buf_in_flit),
    .in_vld (in_valid),
    .in_rdy (in_ready),
    .out_dat(out_flit),
    .out_vld(out_valid),
    .out_rdy(out_ready)
  );

  // Framing FSM. A header always starts a new packet, even mid-packet, and
  // any tail closes it; body flits leave the state alone.
  always_comb begin
    state_d = state_q;
    if (in_xfer) begin
      if (tail_in)     state_d = ST_IDLE;
      else if (hdr_in) state_d = ST_PKT;
    end
  end

  // The outgoing header already carries the substituted destport.
  always_comb begin
    cur_lkdestport_d = cur_lkdestport_q;
    if (out_xfer && out_flit[HDR_BIT]) cur_lkdestport_d = out_flit[DSTP_LSB +: DSTPw];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cur_lkdestport_q <= '0;
    end else begin
      state_q          <= state_d;
      cur_lkdestport_q <= cur_lkdestport_d;
    end
  end

  assign cur_lkdestport = cur_lkdestport_q;

`ifdef LKH_ROUTE_CHECK_EN
  logic proto_err_q, proto_err_d;

  // Body/tail with no open packet, or a header cutting into an open one.
  always_comb begin
    proto_err_d = proto_err_q;
    if (in_xfer && (((state_q == ST_IDLE) && !hdr_in) ||
                    ((state_q == ST_PKT) && hdr_in))) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) proto_err_q <= 1'b0;
    else       proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;
`else
  logic unused_state;
  assign unused_state = (state_q == ST_PKT);
  assign proto_err    = 1'b0;
`endif

endmodule

// File: tb/tb_lkh_route_stage.sv
// Bench for lkh_route_stage: MESH 4x4 XY, router (1,1), linear addresses y*4+x.
module tb_lkh_route_stage;

  localparam int P     = 5;
  localparam int RAW   = 4;
  localparam int FW    = 64;
  localparam int DSTPW = 4;
`ifdef LKH_ROUTE_CHECK_EN
  localparam logic PE_EXP = 1'b1;
`else
  localparam logic PE_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [RAW-1:0]   current_r_addr;
  logic [P*RAW-1:0] neighbors_r_addr;
  logic [FW-1:0]    in_flit, out_flit;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [DSTPW-1:0] cur_lkdestport;
  logic             proto_err;

  int               checks = 0;
  int               errors = 0;
  logic [FW-1:0]    sb[$];
  logic [DSTPW-1:0] exp_cur = '0;

  always #5 clk = ~clk;

  lkh_route_stage #(
    .T1(4), .T2(4), .RAw(RAW), .EAw(4), .DAw(4), .Fw(FW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .current_r_addr  (current_r_addr),
    .neighbors_r_addr(neighbors_r_addr),
    .in_flit         (in_flit),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_flit        (out_flit),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .cur_lkdestport  (cur_lkdestport),
    .proto_err       (proto_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference look-ahead: router (1,1); E=x+1, N=y-1, W=x-1, S=y+1; XY order.
  function automatic logic [3:0] model_lk(input logic [3:0] da, input logic [3:0] dp);
    int nx, ny, tx, ty;
    nx = 1; ny = 1;
    case (dp)
      4'd1: nx = 2;
      4'd2: ny = 0;
      4'd3: nx = 0;
      4'd4: ny = 2;
      default: ;
    endcase
    tx = int'(da) % 4;
    ty = int'(da) / 4;
    if (tx > nx) return 4'd1;
    if (tx < nx) return 4'd3;
    if (ty > ny) return 4'd4;
    if (ty < ny) return 4'd2;
    return 4'd0;
  endfunction

  function automatic logic [63:0] exp_flit(input logic [63:0] f);
    logic [63:0] r;
    r = f;
    if (f[63]) r[3:0] = model_lk(f[7:4], f[3:0]);
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop/compare on output transfer.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      sb.delete();
      exp_cur = '0;
    end else begin
      check("cur_lkdestport", 64'(cur_lkdestport), 64'(exp_cur));
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow: observed output %h expected no output", out_flit);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_flit", out_flit, e);
          if (e[63]) exp_cur = e[3:0];
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_flit(in_flit));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] f);
    int w;
    in_flit  = f;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      step();
      w++;
    end
    check("send_timeout", 64'(w < 200), 64'd1);
    step();
  endtask

  task automatic pulse_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic gen_flit(inout int rem, output logic [63:0] f);
    int len;
    f = {$urandom, $urandom};
    if (rem == 0) begin
      len     = int'($urandom_range(1, 4));
      f[63]   = 1'b1;
      f[62]   = (len == 1);
      f[3:0]  = 4'($urandom_range(0, 4));
      rem     = len - 1;
    end else begin
      rem   = rem - 1;
      f[63] = 1'b0;
      f[62] = (rem == 0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0]  t_da[5] = '{4'd7, 4'd7, 4'd5, 4'd13, 4'd4};
    logic [3:0]  t_dp[5] = '{4'd1, 4'd2, 4'd0, 4'd4,  4'd3};
    logic [3:0]  t_lk[5] = '{4'd1, 4'd1, 4'd0, 4'd4,  4'd0};
    logic        t_rdy[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] f, e, pk[6];
    int          idx, sent, rem, cyc;
    logic        have;

    reset            = 1'b1;
    in_valid         = 1'b0;
    in_flit          = '0;
    out_ready        = 1'b1;
    current_r_addr   = 4'd5;
    neighbors_r_addr = {4'd9, 4'd4, 4'd1, 4'd6, 4'd5};
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cur_lk", 64'(cur_lkdestport), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);

    // Single-flit packets with hand-computed look-ahead ports
    for (int i = 0; i < 5; i++) begin
      f = {1'b1, 1'b1, 50'h1234_5678_9ABC, 4'h2, t_da[i], t_dp[i]};
      e = {1'b1, 1'b1, 50'h1234_5678_9ABC, 4'h2, t_da[i], t_lk[i]};
      send(f);
      in_valid = 1'b0;
      check("single_vld", 64'(out_valid), 64'd1);
      check("single_flit", out_flit, e);
      step();
      check("single_cur_lk", 64'(cur_lkdestport), 64'(t_lk[i]));
    end
    step();

    // 4-flit packet streamed: one output per cycle, no gaps
    send({1'b1, 1'b0, 50'h3_0000_0001, 4'h1, 4'd15, 4'd1});
    check("stream_vld0", 64'(out_valid), 64'd1);
    for (int i = 1; i < 4; i++) begin
      send({1'b0, (i == 3), 50'h5_0000_0000 + 50'(i), 12'hABC});
      check("stream_vld", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_vld", 64'(out_valid), 64'd0);
    check("stream_proto_err", 64'(proto_err), 64'd0);

    // Stall: out_ready low for 5 cycles while 6 flits are offered
    pk[0] = {1'b1, 1'b0, 50'h0_7777_0000, 4'h3, 4'd0, 4'd2};
    for (int i = 1; i < 6; i++) begin
      f = {$urandom, $urandom};
      f[63] = 1'b0;
      f[62] = (i == 5);
      pk[i] = f;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_flit  = pk[idx];
      in_valid = 1'b1;
      check("stall_in_ready", 64'(in_ready), 64'(t_rdy[c]));
      if (c >= 1) check("stall_hold", out_flit, exp_flit(pk[0]));
      if (in_ready) idx++;
      step();
    end
    check("stall_accepted", 64'(idx), 64'd2);
    check("stall_full_rdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    while (idx < 6) begin
      send(pk[idx]);
      idx++;
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("stall_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of a 4-flit packet
    send({1'b1, 1'b0, 50'h0_1111_0000, 4'h1, 4'd3, 4'd1});
    send({1'b0, 1'b0, 62'h0BAD_F00D});
    pulse_reset();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_cur_lk", 64'(cur_lkdestport), 64'd0);
    f = {1'b1, 1'b1, 50'h0_2222_0000, 4'h7, 4'd12, 4'd3};
    send(f);
    in_valid = 1'b0;
    check("midrst_hdr", out_flit, {1'b1, 1'b1, 50'h0_2222_0000, 4'h7, 4'd12, 4'd4});
    step();
    check("midrst_proto_err", 64'(proto_err), 64'd0);

    // Body flit with no open packet: forwarded, error flag if checking enabled
    send({1'b0, 1'b0, 62'h0000_0000_0C0F_FEE0});
    in_valid = 1'b0;
    check("orphan_vld", 64'(out_valid), 64'd1);
    check("orphan_proto_err", 64'(proto_err), 64'(PE_EXP));
    send({1'b1, 1'b1, 50'h0_3333_0000, 4'h2, 4'd6, 4'd0});
    in_valid = 1'b0;
    repeat (2) step();
    check("sticky_proto_err", 64'(proto_err), 64'(PE_EXP));
    check("orphan_drained", 64'(sb.size()), 64'd0);
    pulse_reset();
    check("cleared_proto_err", 64'(proto_err), 64'd0);

    // Random valid/ready over 10k well-formed flits
    sent = 0; rem = 0; cyc = 0; have = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!have) begin
        gen_flit(rem, f);
        have = 1'b1;
      end
      in_flit   = f;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        have = 1'b0;
        sent++;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_sent", 64'(sent), 64'd10000);
    repeat (5) step();
    check("rand_drained", 64'(sb.size()), 64'd0);
    check("rand_proto_err", 64'(proto_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
